// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and fetch sequencing for instruction_memory.
// Advances the PC on fetch_en, redirects on execute-stage flush, flags the
// wrong-path slots still in flight with kill, and supports halt/boot.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- when defined, a redirect to
// a non word-aligned target traps into a sticky FAULT state instead of being
// silently aligned.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned SQUASH_DEPTH = 2,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic [31:0] long_instruction_addr,
    output logic        instr_valid,
    output logic        kill,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_SQUASH,
        ST_HALTED,
        ST_FAULT
    } state_t;

    localparam logic [2:0] DEPTH_C = 3'(SQUASH_DEPTH);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [2:0]  squash_cnt_q;
    logic        instr_valid_q;
    logic        kill_q;
    logic        halted_q;

    logic [31:0] pc_inc_d;
    logic [31:0] redirect_pc_d;
    logic [2:0]  squash_dec_d;
    logic        bad_redirect_d;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        fault_q;
    logic [31:0] fault_addr_q;
`endif

    // Next-PC candidates and redirect qualification
    always_comb begin
        pc_inc_d       = pc_q + PC_STEP;
        redirect_pc_d  = redirect_addr & ~32'h0000_0003;
        squash_dec_d   = squash_cnt_q - 3'd1;
`ifdef FETCH_ALIGN_CHECK_EN
        bad_redirect_d = redirect && (redirect_addr[1:0] != 2'b00);
`else
        bad_redirect_d = 1'b0;
`endif
    end

    // Fetch sequencing FSM; all outputs registered here
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            squash_cnt_q  <= '0;
            instr_valid_q <= 1'b0;
            kill_q        <= 1'b0;
            halted_q      <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q       <= ST_RUN;
                    instr_valid_q <= 1'b1;
                end

                ST_RUN: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (bad_redirect_d) begin
                        state_q       <= ST_FAULT;
                        fault_q       <= 1'b1;
                        fault_addr_q  <= redirect_addr;
                        instr_valid_q <= 1'b0;
                        kill_q        <= 1'b0;
                        halted_q      <= 1'b0;
                        squash_cnt_q  <= '0;
                    end else
`endif
                    if (redirect) begin
                        state_q      <= ST_SQUASH;
                        pc_q         <= redirect_pc_d;
                        squash_cnt_q <= DEPTH_C;
                        kill_q       <= 1'b1;
                    end else if (halt) begin
                        state_q       <= ST_HALTED;
                        instr_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end else if (fetch_en) begin
                        pc_q <= pc_inc_d;
                    end
                end

                ST_SQUASH: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (bad_redirect_d) begin
                        state_q       <= ST_FAULT;
                        fault_q       <= 1'b1;
                        fault_addr_q  <= redirect_addr;
                        instr_valid_q <= 1'b0;
                        kill_q        <= 1'b0;
                        halted_q      <= 1'b0;
                        squash_cnt_q  <= '0;
                    end else
`endif
                    if (redirect) begin
                        pc_q         <= redirect_pc_d;
                        squash_cnt_q <= DEPTH_C;
                        kill_q       <= 1'b1;
                    end else if (halt) begin
                        // squash_cnt and kill survive the halt so the
                        // remaining wrong-path slots are still flushed
                        state_q       <= ST_HALTED;
                        instr_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end else if (fetch_en) begin
                        pc_q         <= pc_inc_d;
                        squash_cnt_q <= squash_dec_d;
                        if (squash_dec_d == 3'd0) begin
                            kill_q  <= 1'b0;
                            state_q <= ST_RUN;
                        end
                    end
                end

                ST_HALTED: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (bad_redirect_d) begin
                        state_q       <= ST_FAULT;
                        fault_q       <= 1'b1;
                        fault_addr_q  <= redirect_addr;
                        instr_valid_q <= 1'b0;
                        kill_q        <= 1'b0;
                        halted_q      <= 1'b0;
                        squash_cnt_q  <= '0;
                    end else
`endif
                    if (redirect) begin
                        pc_q         <= redirect_pc_d;
                        squash_cnt_q <= DEPTH_C;
                        kill_q       <= 1'b1;
                    end else if (!halt) begin
                        state_q       <= (squash_cnt_q != 3'd0) ? ST_SQUASH : ST_RUN;
                        instr_valid_q <= 1'b1;
                        halted_q      <= 1'b0;
                    end
                end

                ST_FAULT: begin
                    // Sticky until reset
                    state_q <= ST_FAULT;
                end

                default: begin
                    state_q       <= ST_BOOT;
                    pc_q          <= RESET_PC;
                    squash_cnt_q  <= '0;
                    instr_valid_q <= 1'b0;
                    kill_q        <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign long_instruction_addr = pc_q;
    assign instr_valid           = instr_valid_q;
    assign kill                  = kill_q;
    assign halted                = halted_q;

`ifdef FETCH_ALIGN_CHECK_EN
    assign fault                 = fault_q;
    assign fault_addr            = fault_addr_q;
`else
    assign fault                 = 1'b0;
    assign fault_addr            = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed plus randomized stimulus for fetch_pc_unit,
// compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH   = 2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        halt = 1'b0;
    logic [31:0] addr;
    logic        valid, kill, halted, fault;
    logic [31:0] fault_addr;

    logic        redirect_w = 1'b0;
    logic        halt_w = 1'b0;
    logic [31:0] addr_w;
    logic        valid_w, kill_w, halted_w, fault_w;
    logic [31:0] fault_addr_w;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_fa;
    bit          m_boot, m_halted, m_fault;
    int          m_pending;

    always #5 clock = ~clock;

    fetch_pc_unit #(.RESET_PC(RST_PC), .SQUASH_DEPTH(DEPTH), .PC_STEP(32'd4)) dut (
        .clock(clock), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_addr(redirect_addr), .halt(halt),
        .long_instruction_addr(addr), .instr_valid(valid), .kill(kill),
        .halted(halted), .fault(fault), .fault_addr(fault_addr)
    );

    fetch_pc_unit #(.RESET_PC(WRAP_PC), .SQUASH_DEPTH(DEPTH), .PC_STEP(32'd4)) dut_w (
        .clock(clock), .reset(reset), .fetch_en(fetch_en), .redirect(redirect_w),
        .redirect_addr(redirect_addr), .halt(halt_w),
        .long_instruction_addr(addr_w), .instr_valid(valid_w), .kill(kill_w),
        .halted(halted_w), .fault(fault_w), .fault_addr(fault_addr_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock edge of the fetch rules, highest priority first
    task automatic model_update();
        if (!reset) begin
            m_pc = RST_PC; m_fa = '0; m_boot = 1; m_halted = 0; m_fault = 0; m_pending = 0;
        end else if (m_fault) begin
            // frozen until reset
        end else if (m_boot) begin
            m_boot = 0;
        end else if (redirect && ALIGN_CHK && (redirect_addr % 4 != 0)) begin
            m_fault = 1; m_fa = redirect_addr; m_halted = 0; m_pending = 0;
        end else if (redirect) begin
            m_pc = redirect_addr - (redirect_addr % 4);
            m_pending = DEPTH;
        end else if (m_halted) begin
            if (!halt) m_halted = 0;
        end else if (halt) begin
            m_halted = 1;
        end else if (fetch_en) begin
            m_pc = m_pc + 32'd4;
            if (m_pending > 0) m_pending--;
        end
    endtask

    task automatic check_model();
        check("addr",       addr,       m_pc);
        check("instr_valid", {31'b0, valid},  {31'b0, !(m_boot || m_halted || m_fault)});
        check("kill",       {31'b0, kill},   {31'b0, (m_pending != 0)});
        check("halted",     {31'b0, halted}, {31'b0, m_halted});
        check("fault",      {31'b0, fault},  {31'b0, m_fault});
        check("fault_addr", fault_addr, m_fa);
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_model();
    endtask

    initial begin
        logic [31:0] r;

        // Reset held for two cycles, then BOOT and sequential fetch
        reset = 0; fetch_en = 1;
        step(); step();
        check("rst_addr", addr, 32'h0);
        check("rst_valid", {31'b0, valid}, 32'h0);
        reset = 1;
        step(); check("boot_addr", addr, 32'h0); check("boot_valid", {31'b0, valid}, 32'h1);
        step(); check("seq_4", addr, 32'h4);
        step(); check("seq_8", addr, 32'h8);

        // Redirect from 0x8 to 0x40: two killed slots
        redirect = 1; redirect_addr = 32'h40;
        step(); check("redir_addr", addr, 32'h40); check("redir_kill", {31'b0, kill}, 32'h1);
        redirect = 0;
        step(); check("sq_44", addr, 32'h44); check("sq_44_kill", {31'b0, kill}, 32'h1);
        step(); check("sq_48", addr, 32'h48); check("sq_48_kill", {31'b0, kill}, 32'h0);

        // Reach pc=0x10 through another redirect, then halt 3 cycles
        redirect = 1; redirect_addr = 32'h8; step();
        redirect = 0; step(); step();
        check("pre_halt", addr, 32'h10);
        halt = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_addr", addr, 32'h10);
            check("halt_flag", {31'b0, halted}, 32'h1);
        end
        halt = 0;
        step(); check("resume_10", addr, 32'h10); check("resume_valid", {31'b0, valid}, 32'h1);
        step(); check("resume_14", addr, 32'h14);

        // Redirect while squashing with one slot left
        redirect = 1; redirect_addr = 32'h20; step();
        redirect = 0; step();
        redirect = 1; redirect_addr = 32'h80; step();
        check("re_redir", addr, 32'h80);
        redirect = 0;
        step(); check("re_84_kill", {31'b0, kill}, 32'h1);
        step(); check("re_88", addr, 32'h88); check("re_88_kill", {31'b0, kill}, 32'h0);

        // Halt during squash, redirect while halted, then release
        redirect = 1; redirect_addr = 32'h100; step();
        redirect = 0; halt = 1; step();
        check("sqhalt_kill", {31'b0, kill}, 32'h1);
        redirect = 1; redirect_addr = 32'h200; step();
        check("halt_redir", addr, 32'h200);
        redirect = 0; halt = 0;
        step(); step(); step();
        check("post_208", addr, 32'h208);

        // Misaligned redirect target
        redirect = 1; redirect_addr = 32'h42; step();
        redirect = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'b0, fault}, 32'h1);
        check("mis_faddr", fault_addr, 32'h42);
        step(); step();
        check("mis_frozen", addr, 32'h208);
`else
        check("mis_addr", addr, 32'h40);
        check("mis_fault", {31'b0, fault}, 32'h0);
        step();
`endif

        // Reset mid-SQUASH clears kill immediately
        redirect = 1; redirect_addr = 32'h300; step();
        redirect = 0; reset = 0; step();
        check("rst_kill", {31'b0, kill}, 32'h0);
        check("rst_pc", addr, RST_PC);

        // PC wrap on the second instance
        reset = 1; fetch_en = 1;
        step(); check("wrap_f8", addr_w, 32'hFFFF_FFF8); check("wrap_valid", {31'b0, valid_w}, 32'h1);
        step(); check("wrap_fc", addr_w, 32'hFFFF_FFFC);
        step(); check("wrap_0", addr_w, 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(39) != 0);
            fetch_en = ($urandom_range(3) != 0);
            redirect = ($urandom_range(5) == 0);
            if ($urandom_range(4) == 0) halt = ~halt;
            r = $urandom;
            if ($urandom_range(7) == 0) r[1:0] = 2'($urandom_range(3, 1));
            else r[1:0] = 2'b00;
            redirect_addr = r;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
